// File: rtl/irq_pending_capture_pkg.sv
// ---------------------------------------------------------------------------
// irq_pending_capture_pkg
// Shared constants and types for the 4-line interrupt capture front-end.
//   N_IRQ       : number of request lines (matches the external 4x2 encoder)
//   ID_W        : interrupt id width, clog2(N_IRQ)
//   irq_state_e : presentation FSM states (IDLE=0, PRESENT=1)
//   id_onehot() : id -> one-hot line vector
// ---------------------------------------------------------------------------
package irq_pending_capture_pkg;

  localparam int N_IRQ = 4;
  localparam int ID_W  = 2;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } irq_state_e;

  function automatic logic [N_IRQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    return N_IRQ'(1) << id;
  endfunction

endpackage

// File: rtl/irq_pending_capture_if.sv
// ---------------------------------------------------------------------------
// irq_pending_capture_if
// Valid/ready channel carrying the winning interrupt id to the consumer.
//   irq_valid : an id is presented
//   irq_id    : presented id, stable while irq_valid=1
//   irq_ready : consumer accepts when irq_valid & irq_ready
// Modports: master (capture block side), slave (consumer side).
// ---------------------------------------------------------------------------
interface irq_pending_capture_if
  import irq_pending_capture_pkg::*;
  ;

  logic            irq_valid;
  logic [ID_W-1:0] irq_id;
  logic            irq_ready;

  modport master (output irq_valid, output irq_id, input irq_ready);
  modport slave  (input irq_valid, input irq_id, output irq_ready);

endinterface

// File: rtl/irq_sync_edge.sv
// ---------------------------------------------------------------------------
// irq_sync_edge
// Synchronizes one asynchronous request line and produces a registered
// single-cycle pulse on each rising edge of the synchronized signal.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high
//   req  : asynchronous request line
//   rise : one-cycle pulse, registered
// Parameter SYNC_STAGES: synchronizer depth, legal range 2..3.
// ---------------------------------------------------------------------------
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_d_reg;
  logic                   rise_reg;

  // The rise pulse is registered so that a request sampled at edge 0 sets
  // the pending bit at edge SYNC_STAGES+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg   <= '0;
      sync_d_reg <= 1'b0;
      rise_reg   <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[SYNC_STAGES-2:0], req};
      sync_d_reg <= sync_reg[SYNC_STAGES-1];
      rise_reg   <= sync_reg[SYNC_STAGES-1] & ~sync_d_reg;
    end
  end

  assign rise = rise_reg;

endmodule

// File: rtl/irq_pending_capture.sv
// ---------------------------------------------------------------------------
// irq_pending_capture
// Front-end of the 4-line interrupt path: synchronizes the request lines,
// captures rising edges into a pending register, and presents the winner
// chosen by an external 4x2 priority encoder over a valid/ready channel.
// The pending bit of the accepted id is cleared on the handshake.
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous reset, active-high
//   irq_in   : async request lines, event = rising edge
//   pend_o   : pending vector to encoder I[3:0]
//   enc_y_i  : encoder Y (winning index)
//   enc_v_i  : encoder V (any pending)
//   irq_mask : (IRQ_MASK_EN only) 1 = line hidden from the encoder
//   ovf      : sticky, edge arrived while that line was already pending
//   ovf_clr  : clears all ovf bits (a same-cycle set wins)
//   irq_bus  : consumer channel (irq_valid / irq_id / irq_ready)
// Optional feature macro: IRQ_MASK_EN adds irq_mask. Masked lines keep
// capturing and holding pending; an id already presented is not withdrawn.
// ---------------------------------------------------------------------------
module irq_pending_capture
  import irq_pending_capture_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_IRQ-1:0]     irq_in,
  output logic [N_IRQ-1:0]     pend_o,
  input  logic [ID_W-1:0]      enc_y_i,
  input  logic                 enc_v_i,
`ifdef IRQ_MASK_EN
  input  logic [N_IRQ-1:0]     irq_mask,
`endif
  output logic [N_IRQ-1:0]     ovf,
  input  logic                 ovf_clr,
  irq_pending_capture_if.master irq_bus
);

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] pending_reg, pending_next;
  logic [N_IRQ-1:0] ovf_reg, ovf_next;
  logic [N_IRQ-1:0] clr;
  logic [N_IRQ-1:0] ovf_set;
  logic             handshake;

  irq_state_e       state_reg, state_next;
  logic [ID_W-1:0]  irq_id_reg, irq_id_next;

  genvar gi;
  generate
    for (gi = 0; gi < N_IRQ; gi++) begin : g_line
      irq_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
      ) u_sync_edge (
        .clk  (clk),
        .rst  (rst),
        .req  (irq_in[gi]),
        .rise (rise[gi])
      );
    end
  endgenerate

  assign handshake = (state_reg == PRESENT) & irq_bus.irq_ready;

  // Pending / overflow update. A rise on the bit being accepted re-arms it,
  // so the set term is OR-ed in after the clear.
  always_comb begin
    clr          = handshake ? id_onehot(irq_id_reg) : '0;
    pending_next = (pending_reg & ~clr) | rise;
    ovf_set      = rise & pending_reg & ~clr;
    ovf_next     = ovf_clr ? ovf_set : (ovf_reg | ovf_set);
  end

  // Presentation FSM. The id is latched on entry to PRESENT and frozen there
  // (no preemption), so the encoder output is only looked at in IDLE.
  always_comb begin
    state_next  = state_reg;
    irq_id_next = irq_id_reg;
    case (state_reg)
      IDLE: begin
        if (enc_v_i) begin
          state_next  = PRESENT;
          irq_id_next = enc_y_i;
        end
      end
      PRESENT: begin
        if (irq_bus.irq_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      irq_id_reg  <= '0;
      pending_reg <= '0;
      ovf_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      irq_id_reg  <= irq_id_next;
      pending_reg <= pending_next;
      ovf_reg     <= ovf_next;
    end
  end

`ifdef IRQ_MASK_EN
  assign pend_o = pending_reg & ~irq_mask;
`else
  assign pend_o = pending_reg;
`endif

  assign ovf               = ovf_reg;
  assign irq_bus.irq_valid = (state_reg == PRESENT);
  assign irq_bus.irq_id    = irq_id_reg;

endmodule

// File: tb/tb_irq_pending_capture.sv
// ---------------------------------------------------------------------------
// tb_irq_pending_capture
// Closed-loop bench: the DUT's pend_o feeds a behavioural 4x2 priority
// encoder (line 0 highest) whose Y/V return to the DUT. A reference model
// tracks request history, pending, overflow and the presented id; a
// compare process checks the DUT against it on every falling edge, and a
// directed sequence pins the model with hand-computed values.
// Define IRQ_MASK_EN to exercise the mask option.
// ---------------------------------------------------------------------------
module tb_irq_pending_capture;
  import irq_pending_capture_pkg::*;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] irq_in = 4'b0;
  logic [3:0] pend_o;
  logic [1:0] enc_y;
  logic       enc_v;
  logic [3:0] ovf;
  logic       ovf_clr = 1'b0;
  logic [3:0] mask = 4'b0;

  irq_pending_capture_if bus();

  irq_pending_capture #(.SYNC_STAGES(S)) dut (
    .clk     (clk),
    .rst     (rst),
    .irq_in  (irq_in),
    .pend_o  (pend_o),
    .enc_y_i (enc_y),
    .enc_v_i (enc_v),
`ifdef IRQ_MASK_EN
    .irq_mask(mask),
`endif
    .ovf     (ovf),
    .ovf_clr (ovf_clr),
    .irq_bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural priority encoder: lowest set index wins.
  always_comb begin
    enc_v = |pend_o;
    enc_y = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pend_o[i]) enc_y = 2'(i);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // hist[i][k] = irq_in[i] sampled k+1 edges ago. A line's edge takes
  // effect S+1 edges after the first high sample.
  bit [7:0] hist [4];
  bit [3:0] m_pend, m_ovf;
  bit       m_valid;
  int       m_id;

  always @(posedge clk) begin
    bit [3:0] rise_v, clr_v, set_v, vis;
    int nid;
    if (rst) begin
      for (int i = 0; i < 4; i++) hist[i] = 8'd0;
      m_pend = 4'd0; m_ovf = 4'd0; m_valid = 1'b0; m_id = 0;
    end else begin
      rise_v = 4'd0;
      for (int i = 0; i < 4; i++)
        if (hist[i][S] && !hist[i][S+1]) rise_v[i] = 1'b1;
      clr_v = 4'd0;
      if (m_valid && bus.irq_ready) clr_v[m_id] = 1'b1;
      set_v = rise_v & m_pend & ~clr_v;
      m_ovf = ovf_clr ? set_v : (m_ovf | set_v);
      if (m_valid) begin
        if (bus.irq_ready) m_valid = 1'b0;
      end else begin
        vis = m_pend & ~mask;
        nid = 0;
        for (int i = 3; i >= 0; i--) if (vis[i]) nid = i;
        if (vis != 4'd0) begin
          m_valid = 1'b1;
          m_id = nid;
        end
      end
      m_pend = (m_pend & ~clr_v) | rise_v;
      for (int i = 0; i < 4; i++) hist[i] = {hist[i][6:0], irq_in[i]};
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("model_pend", pend_o, m_pend & ~mask);
      check("model_ovf", ovf, m_ovf);
      check("model_valid", {3'b0, bus.irq_valid}, {3'b0, m_valid});
      if (m_valid) check("model_id", {2'b0, bus.irq_id}, 4'(m_id));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input logic [3:0] v);
    irq_in = v;
    tick();
    irq_in = 4'b0;
  endtask

  task automatic chk_hs(input string name, input logic v, input logic [1:0] id);
    check({name, "_valid"}, {3'b0, bus.irq_valid}, {3'b0, v});
    if (v) check({name, "_id"}, {2'b0, bus.irq_id}, {2'b0, id});
  endtask

  initial begin
    bus.irq_ready = 1'b0;
    ticks(3);
    rst = 1'b0;
    started = 1'b1;
    check("reset_pend", pend_o, 4'b0000);
    check("reset_ovf", ovf, 4'b0000);
    chk_hs("reset", 1'b0, 2'd0);

    // 1: single pulse on line 2, latency and acceptance
    pulse(4'b0100);            // edge 0
    ticks(2);                  // edges 1,2
    check("t1_pend_e2", pend_o, 4'b0000);
    tick();                    // edge 3
    check("t1_pend_e3", pend_o, 4'b0100);
    chk_hs("t1_e3", 1'b0, 2'd0);
    tick();                    // edge 4
    chk_hs("t1_e4", 1'b1, 2'd2);
    bus.irq_ready = 1'b1;
    tick();
    check("t1_pend_acc", pend_o, 4'b0000);
    chk_hs("t1_acc", 1'b0, 2'd0);
    bus.irq_ready = 1'b0;
    tick();

    // 2: lines 1 and 3 together, ready held
    pulse(4'b1010);
    bus.irq_ready = 1'b1;
    ticks(3);
    check("t2_pend", pend_o, 4'b1010);
    tick();
    chk_hs("t2_first", 1'b1, 2'd1);
    tick();
    check("t2_pend_mid", pend_o, 4'b1000);
    tick();
    chk_hs("t2_second", 1'b1, 2'd3);
    tick();
    check("t2_pend_end", pend_o, 4'b0000);
    bus.irq_ready = 1'b0;
    tick();

    // 3: no preemption by a higher-priority line
    pulse(4'b0100);
    ticks(4);
    chk_hs("t3_pres", 1'b1, 2'd2);
    pulse(4'b0001);
    ticks(4);
    check("t3_pend", pend_o, 4'b0101);
    chk_hs("t3_frozen", 1'b1, 2'd2);
    bus.irq_ready = 1'b1;
    tick();
    bus.irq_ready = 1'b0;
    tick();
    chk_hs("t3_next", 1'b1, 2'd0);
    bus.irq_ready = 1'b1;
    tick();
    bus.irq_ready = 1'b0;
    tick();

    // 4: overflow and its clear
    pulse(4'b0100);
    ticks(4);
    pulse(4'b0100);
    ticks(3);
    check("t4_ovf", ovf, 4'b0100);
    check("t4_pend", pend_o, 4'b0100);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t4_ovf_clr", ovf, 4'b0000);
    bus.irq_ready = 1'b1;
    tick();
    bus.irq_ready = 1'b0;
    tick();

    // 5: rise lands on the accepting edge -> set wins
    pulse(4'b0100);
    ticks(4);
    chk_hs("t5_pres", 1'b1, 2'd2);
    pulse(4'b0100);            // edge e0
    ticks(2);                  // e1, e2
    bus.irq_ready = 1'b1;
    tick();                    // e3: accept + set
    check("t5_pend", pend_o, 4'b0100);
    check("t5_ovf", ovf, 4'b0000);
    chk_hs("t5_acc", 1'b0, 2'd0);
    bus.irq_ready = 1'b0;
    tick();
    chk_hs("t5_again", 1'b1, 2'd2);
    bus.irq_ready = 1'b1;
    tick();
    bus.irq_ready = 1'b0;
    tick();

    // 6: reset mid-handshake
    pulse(4'b0010);
    ticks(4);
    chk_hs("t6_pres", 1'b1, 2'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_hs("t6_rst", 1'b0, 2'd0);
    check("t6_pend", pend_o, 4'b0000);
    check("t6_ovf", ovf, 4'b0000);
    tick();

`ifdef IRQ_MASK_EN
    mask = 4'b0100;
    pulse(4'b0100);
    ticks(5);
    check("mask_pend", pend_o, 4'b0000);
    chk_hs("mask_hidden", 1'b0, 2'd0);
    mask = 4'b0000;
    check("mask_unmask", pend_o, 4'b0100);
    tick();
    chk_hs("mask_pres", 1'b1, 2'd2);
    bus.irq_ready = 1'b1;
    tick();
    bus.irq_ready = 1'b0;
    tick();
`endif

    // randomized phase, checked against the model every cycle
    for (int c = 0; c < 4000; c++) begin
      irq_in        = 4'($urandom) & 4'($urandom);
      bus.irq_ready = 1'($urandom_range(0, 1));
      ovf_clr       = ($urandom_range(0, 15) == 0);
      rst           = ($urandom_range(0, 299) == 0);
`ifdef IRQ_MASK_EN
      if ($urandom_range(0, 7) == 0) mask = 4'($urandom);
`endif
      tick();
    end
    rst = 1'b0;
    irq_in = 4'b0;
    ticks(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
